// File: rtl/store_field.sv
// rtl/store_field.sv - MIX partial-field store (STA..STZ) read-modify-write unit
// Define STORE_FULLWORD_BYPASS_EN to write F=(0:5) directly without the read.
module store_field #(
    parameter int MEM_WORDS = 4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] addr,
    input  logic [5:0]  field,
    input  logic [30:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [30:0] mem_rdata,
    output logic        mem_we,
    output logic [30:0] mem_wdata
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, FAIL} state_t;

    state_t      state, state_nx;
    logic [11:0] addr_q, addr_nx;
    logic [2:0]  l_q, l_nx, r_q, r_nx;
    logic [30:0] data_q, data_nx;
    logic        busy_nx, done_nx, err_nx, rd_nx, we_nx;
    logic [11:0] maddr_nx;
    logic [30:0] wdata_nx;
    logic        bad_field, bad_addr;

    // Bytes max(L,1)..R take the rightmost source bytes, right-aligned.
    function automatic logic [30:0] merge(input logic [30:0] old, input logic [30:0] src,
                                          input logic [2:0] l, input logic [2:0] r);
        logic [30:0] w;
        int          lo;
        w  = old;
        lo = (l == 3'd0) ? 1 : int'(l);
        if (l == 3'd0) begin
            w[30] = src[30];
        end
        for (int j = 1; j <= 5; j++) begin
            if (j >= lo && j <= int'(r)) begin
                w[(5 - j) * 6 +: 6] = src[(int'(r) - j) * 6 +: 6];
            end
        end
        return w;
    endfunction

    always_comb begin
        bad_field = (field[5:3] > field[2:0]) || (field[2:0] > 3'd5);
        bad_addr  = int'({20'd0, addr}) >= MEM_WORDS;
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        l_nx     = l_q;
        r_nx     = r_q;
        data_nx  = data_q;
        wdata_nx = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nx = addr;
                    l_nx    = field[5:3];
                    r_nx    = field[2:0];
                    data_nx = data;
                    if (bad_field || bad_addr) begin
                        state_nx = FAIL;
                    end
`ifdef STORE_FULLWORD_BYPASS_EN
                    else if (field == 6'd5) begin
                        state_nx = WRITE;
                        wdata_nx = data;
                    end
`endif
                    else begin
                        state_nx = READ;
                    end
                end
            end
            READ:  state_nx = LATCH;
            LATCH: begin
                state_nx = WRITE;
                wdata_nx = merge(mem_rdata, data_q, l_q, r_q);
            end
            WRITE:   state_nx = IDLE;
            FAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from the next state so nothing is combinational.
        busy_nx  = (state_nx != IDLE);
        rd_nx    = (state_nx == READ);
        we_nx    = (state_nx == WRITE);
        done_nx  = (state_nx == WRITE) || (state_nx == FAIL);
        err_nx   = (state_nx == FAIL);
        maddr_nx = busy_nx ? addr_nx : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            l_q       <= '0;
            r_q       <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            l_q       <= l_nx;
            r_q       <= r_nx;
            data_q    <= data_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
            mem_rd    <= rd_nx;
            mem_we    <= we_nx;
            mem_addr  <= maddr_nx;
            mem_wdata <= wdata_nx;
        end
    end

endmodule

// File: tb/tb_store_field.sv
// tb/tb_store_field.sv - self-checking bench for store_field
module tb_store_field;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [11:0] addr;
    logic [5:0]  field;
    logic [30:0] data;
    logic        busy, done, err, mem_rd, mem_we;
    logic [11:0] mem_addr;
    logic [30:0] mem_rdata, mem_wdata;

    logic [30:0] mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [30:0] pl_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] addr;
        logic [5:0]  field;
        logic [30:0] data;
        logic [30:0] old;
        logic [30:0] exp;
        bit          err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [30:0] word;
        bit          err;
        int          lat;
    } sb_t;

    vec_t vt[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    store_field #(.MEM_WORDS(4000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .addr      (addr),
        .field     (field),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [30:0] mk(input bit s, input int b1, input int b2,
                                       input int b3, input int b4, input int b5);
        return {s, b1[5:0], b2[5:0], b3[5:0], b4[5:0], b5[5:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [11:0] a, input logic [5:0] f, input logic [30:0] d,
                       input logic [30:0] o, input logic [30:0] x, input bit e, input int l);
        vec_t v;
        v.addr = a; v.field = f; v.data = d; v.old = o; v.exp = x; v.err = e; v.lat = l;
        vt.push_back(v);
    endtask

    task automatic preload(input logic [11:0] a, input logic [30:0] w);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = w;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        sb_t e;
        bit  got, saw_rd, saw_we;
        preload(v.addr, v.old);
        addr = v.addr; field = v.field; data = v.data; start = 1'b1;
        e.addr = v.addr; e.word = v.exp; e.err = v.err; e.lat = v.lat;
        sb.push_back(e);
        got = 0; saw_rd = 0; saw_we = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rd) saw_rd = 1;
            if (mem_we) saw_we = 1;
            if (done) begin
                got = 1;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL v%0d sb: got unexpected done expected none", i);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d latency", i), c, e.lat);
                    chk($sformatf("v%0d err", i), err, e.err);
                    if (!e.err) begin
                        chk($sformatf("v%0d we", i), mem_we, 1);
                        chk($sformatf("v%0d waddr", i), mem_addr, e.addr);
                        chk($sformatf("v%0d wdata", i), mem_wdata, e.word);
                    end
                end
                break;
            end
            chk($sformatf("v%0d busy c%0d", i, c), busy, 1);
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL v%0d timeout: got no done expected done within 8 cycles", i);
            sb.delete();
        end
        @(negedge clk);
        chk($sformatf("v%0d idle busy", i), busy, 0);
        chk($sformatf("v%0d ram", i), mem[v.addr], v.exp);
        chk($sformatf("v%0d rd seen", i), saw_rd, (!v.err && v.lat == 3));
        chk($sformatf("v%0d we seen", i), saw_we, !v.err);
    endtask

    initial begin
        logic [30:0] o1, s1, o2, s2;
        int          lat05, nwe;
        reset_n = 1'b0; start = 1'b0; addr = '0; field = '0; data = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst ctrl", {busy, done, err, mem_rd, mem_we}, 5'b0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;

        o1 = mk(1, 1, 2, 3, 4, 5);
        s1 = mk(0, 6, 7, 8, 9, 0);
        o2 = mk(0, 63, 62, 61, 60, 59);
        s2 = mk(1, 10, 20, 30, 40, 50);
`ifdef STORE_FULLWORD_BYPASS_EN
        lat05 = 1;
`else
        lat05 = 3;
`endif
        add(12'd10,   6'd13, s1, o1, mk(1, 6, 7, 8, 9, 0), 0, 3);
        add(12'd11,   6'd45, s1, o1, mk(1, 1, 2, 3, 4, 0), 0, 3);
        add(12'd12,   6'd18, s1, o1, mk(1, 1, 0, 3, 4, 5), 0, 3);
        add(12'd13,   6'd1,  s1, o1, mk(0, 0, 2, 3, 4, 5), 0, 3);
        add(12'd14,   6'd0,  s1, o1, mk(0, 1, 2, 3, 4, 5), 0, 3);
        add(12'd15,   6'd5,  s1, o1, s1,                   0, lat05);
        add(12'd16,   6'd28, s1, o1, mk(1, 1, 2, 9, 0, 5), 0, 3);
        add(12'd17,   6'd11, s1, o1, mk(1, 8, 9, 0, 4, 5), 0, 3);
        add(12'd18,   6'd2,  s2, o2, mk(1, 40, 50, 61, 60, 59), 0, 3);
        add(12'd3999, 6'd13, s1, o1, mk(1, 6, 7, 8, 9, 0), 0, 3);
        add(12'd20,   6'd34, s1, o1, o1, 1, 1);
        add(12'd21,   6'd6,  s1, o1, o1, 1, 1);
        add(12'd4000, 6'd5,  s1, o1, o1, 1, 1);
        add(12'd22,   6'd63, s1, o1, o1, 1, 1);

        for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

        // Reset while in LATCH: no write may follow and RAM stays put.
        preload(12'd200, o1);
        addr = 12'd200; field = 6'd13; data = s1; start = 1'b1;
        nwe = 0;
        @(negedge clk);
        start = 1'b0;
        chk("rst-mid rd", mem_rd, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst-mid ctrl", {busy, done, err, mem_rd, mem_we}, 5'b0);
        chk("rst-mid mem_addr", mem_addr, 0);
        chk("rst-mid mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
        end
        chk("rst-mid we count", nwe, 0);
        chk("rst-mid ram", mem[200], o1);

        // Start pulses while busy are dropped; exactly one write lands.
        preload(12'd100, o1);
        preload(12'd101, o2);
        addr = 12'd100; field = 6'd13; data = s1; start = 1'b1;
        nwe = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            start = (c <= 2);
            addr  = 12'd101;
        end
        chk("busy-start we count", nwe, 1);
        chk("busy-start ram a", mem[100], mk(1, 6, 7, 8, 9, 0));
        chk("busy-start ram b", mem[101], o2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
